// File: rtl/pwm_ramp_sequencer.sv
// Duty-cycle ramp sequencer for the PWM comparator core: steps duty toward a target once every N PWM periods.
// Optional PWM_RAMP_RETARGET_EN lets a new command replace the running ramp.
module pwm_ramp_sequencer #(
   parameter int WIDTH  = 8,
   parameter int RATE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              period_tick,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [WIDTH-1:0]  cmd_target,
   input  logic [WIDTH-1:0]  cmd_step,
   input  logic [RATE_W-1:0] cmd_rate,
   input  logic              abort,
   output logic [WIDTH-1:0]  duty,
   output logic              busy,
   output logic              done
);
   typedef enum logic {IDLE, RAMP} state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_tgt;
   logic [WIDTH-1:0]  r_stp;
   logic [RATE_W-1:0] r_rate;
   logic [RATE_W-1:0] r_cnt;
   logic [WIDTH-1:0]  r_duty;
   logic              r_done;

   logic              w_accept;
   logic              w_up;
   logic [WIDTH:0]    w_diff;
   logic              w_last;
   logic              w_cnt_wrap;

`ifdef PWM_RAMP_RETARGET_EN
   assign cmd_ready = (r_state == IDLE) ? 1'b1 : !abort;
`else
   assign cmd_ready = (r_state == IDLE);
`endif

   assign w_accept   = cmd_valid && cmd_ready;
   assign w_up       = r_tgt > r_duty;
   // One extra bit keeps the distance exact so the final step can clamp to target.
   assign w_diff     = w_up ? ({1'b0, r_tgt} - {1'b0, r_duty}) : ({1'b0, r_duty} - {1'b0, r_tgt});
   assign w_last     = w_diff <= {1'b0, r_stp};
   assign w_cnt_wrap = r_cnt == (r_rate - RATE_W'(1));

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= IDLE;
         r_tgt   <= '0;
         r_stp   <= WIDTH'(1);
         r_rate  <= RATE_W'(1);
         r_cnt   <= '0;
         r_duty  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_tgt  <= cmd_target;
            r_stp  <= (cmd_step == '0) ? WIDTH'(1) : cmd_step;
            r_rate <= (cmd_rate == '0) ? RATE_W'(1) : cmd_rate;
            r_cnt  <= '0;
            if (cmd_target == r_duty) begin
               r_state <= IDLE;
               r_done  <= 1'b1;
            end else begin
               r_state <= RAMP;
            end
         end else if (r_state == RAMP) begin
            if (abort) begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end else if (period_tick) begin
               if (w_cnt_wrap) begin
                  r_cnt <= '0;
                  if (w_last) begin
                     r_duty  <= r_tgt;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_duty <= w_up ? (r_duty + r_stp) : (r_duty - r_stp);
                  end
               end else begin
                  r_cnt <= r_cnt + RATE_W'(1);
               end
            end
         end
      end
   end

   assign duty = r_duty;
   assign busy = (r_state == RAMP);
   assign done = r_done;
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: table of ramp commands plus abort, reset and retarget sequences.
module tb_pwm_ramp_sequencer;
   logic        clk;
   logic        rst_n;
   logic        period_tick;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_target;
   logic [7:0]  cmd_step;
   logic [15:0] cmd_rate;
   logic        abort;
   logic [7:0]  duty;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   pwm_ramp_sequencer #(.WIDTH(8), .RATE_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .period_tick(period_tick),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_rate(cmd_rate),
      .abort(abort), .duty(duty), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  tgt;
      logic [7:0]  stp;
      logic [15:0] rate;
      int          gap;
      int          nsteps;
      logic [31:0] exp;
   } ramp_t;

   ramp_t vec [6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   task automatic issue(input int t, input int s, input int r);
      cmd_valid  = 1'b1;
      cmd_target = 8'(t);
      cmd_step   = 8'(s);
      cmd_rate   = 16'(r);
      #1 chk("ready_before_cmd", int'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic tick1();
      period_tick = 1'b1;
      @(negedge clk);
      period_tick = 1'b0;
   endtask

   int cur;
   int re;

   initial begin
      rst_n = 1'b1; period_tick = 1'b0; cmd_valid = 1'b0;
      cmd_target = '0; cmd_step = '0; cmd_rate = '0; abort = 1'b0;

      vec[0] = '{8'd40,  8'd10,  16'd2, 5, 4, pk(10, 20, 30, 40)};
      vec[1] = '{8'd5,   8'd10,  16'd1, 3, 4, pk(30, 20, 10, 5)};
      vec[2] = '{8'd253, 8'd124, 16'd1, 1, 2, pk(129, 253, 0, 0)};
      vec[3] = '{8'd255, 8'd0,   16'd0, 1, 2, pk(254, 255, 0, 0)};
      vec[4] = '{8'd255, 8'd3,   16'd4, 1, 0, pk(0, 0, 0, 0)};
      vec[5] = '{8'd0,   8'd200, 16'd3, 2, 2, pk(55, 0, 0, 0)};

      repeat (2) @(negedge clk);
      chk("rst_duty", int'(duty), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      rst_n = 1'b0;
      @(negedge clk);
      cur = 0;

      for (int i = 0; i < 6; i++) begin
         re = (vec[i].rate == 0) ? 1 : int'(vec[i].rate);
         issue(vec[i].tgt, vec[i].stp, vec[i].rate);
         if (vec[i].nsteps == 0) begin
            chk("match_done", int'(done), 1);
            chk("match_busy", int'(busy), 0);
            chk("match_duty", int'(duty), cur);
            @(negedge clk);
            chk("match_done_pulse", int'(done), 0);
         end else begin
            chk("acc_busy", int'(busy), 1);
            chk("acc_done", int'(done), 0);
         end
         for (int k = 0; k < vec[i].nsteps; k++) begin
            for (int j = 0; j < re; j++) begin
               tick1();
               if (j < re - 1) begin
                  chk("hold_duty", int'(duty), cur);
               end else begin
                  cur = int'(vec[i].exp[k*8 +: 8]);
                  chk("step_duty", int'(duty), cur);
                  chk("step_done", int'(done), (k == vec[i].nsteps - 1) ? 1 : 0);
                  chk("step_busy", int'(busy), (k == vec[i].nsteps - 1) ? 0 : 1);
                  if (k == vec[i].nsteps - 1) begin
                     chk("end_ready", int'(cmd_ready), 1);
                     @(negedge clk);
                     chk("done_pulse", int'(done), 0);
                  end
               end
               for (int g = 1; g < vec[i].gap; g++) @(negedge clk);
            end
         end
      end

      // abort together with a step-completing tick: duty holds pre-step value
      issue(100, 10, 2);
      tick1(); tick1();
      chk("abort_pre_duty", int'(duty), 10);
      tick1();
      period_tick = 1'b1; abort = 1'b1;
      #1 chk("abort_ready_ramp", int'(cmd_ready), 0);
      @(negedge clk);
      period_tick = 1'b0; abort = 1'b0;
      chk("abort_duty", int'(duty), 10);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_ready", int'(cmd_ready), 1);
      abort = 1'b1;
      #1 chk("abort_idle_ready", int'(cmd_ready), 1);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_no_done", int'(done), 0);
      chk("abort_idle_duty", int'(duty), 10);

      // asynchronous reset between edges mid-ramp
      issue(100, 10, 1);
      tick1();
      chk("rstm_pre_duty", int'(duty), 20);
      #2 rst_n = 1'b1;
      #1;
      chk("rstm_duty", int'(duty), 0);
      chk("rstm_busy", int'(busy), 0);
      chk("rstm_done", int'(done), 0);
      #1 rst_n = 1'b0;
      @(negedge clk);
      tick1(); tick1(); tick1();
      chk("rstm_no_resume_duty", int'(duty), 0);
      chk("rstm_no_resume_busy", int'(busy), 0);

      // new command presented mid-ramp at duty=30
      issue(100, 10, 1);
      tick1(); tick1(); tick1();
      chk("rt_pre_duty", int'(duty), 30);
      cmd_valid = 1'b1; cmd_target = 8'd0; cmd_step = 8'd10; cmd_rate = 16'd1;
      period_tick = 1'b1;
`ifdef PWM_RAMP_RETARGET_EN
      #1 chk("rt_ready", int'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rt_hold_duty", int'(duty), 30);
      chk("rt_busy", int'(busy), 1);
      @(negedge clk); chk("rt_d20", int'(duty), 20);
      @(negedge clk); chk("rt_d10", int'(duty), 10);
      @(negedge clk);
      period_tick = 1'b0;
      chk("rt_d0", int'(duty), 0);
      chk("rt_done", int'(done), 1);
      chk("rt_end_busy", int'(busy), 0);
`else
      #1 chk("rt_ready_ramp", int'(cmd_ready), 0);
      repeat (7) @(negedge clk);
      period_tick = 1'b0;
      chk("rt_first_duty", int'(duty), 100);
      chk("rt_first_done", int'(done), 1);
      chk("rt_first_ready", int'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rt_acc_busy", int'(busy), 1);
      chk("rt_acc_duty", int'(duty), 100);
      period_tick = 1'b1;
      repeat (10) @(negedge clk);
      period_tick = 1'b0;
      chk("rt_d0", int'(duty), 0);
      chk("rt_done", int'(done), 1);
      chk("rt_end_busy", int'(busy), 0);
`endif
      @(negedge clk);
      chk("rt_done_pulse", int'(done), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pwm_ramp_sequencer.md
# pwm_ramp_sequencer

Duty-cycle sequencer that sits in front of the 8-bit PWM comparator core and drives its duty input. It accepts a ramp command (target, step size, rate) over a valid/ready handshake. It then moves the duty value toward the target by a fixed step once every N PWM periods, and pulses `done` on arrival. Typical uses are soft-start, fades and controlled motor/LED transitions without per-period CPU writes.

## Interface
Parameters:
- `WIDTH`, 8: duty and target width; must match the PWM core compare width.
- `RATE_W`, 16: width of the rate field and of the internal period counter.

Ports:
- `clk` in 1: single system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-high reset. The port name is kept from the codebase; a high level resets the block.
- `period_tick` in 1: one-cycle pulse from the PWM core at the start of each PWM period.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_target` in WIDTH: final duty value.
- `cmd_step` in WIDTH: duty change per step; 0 is treated as 1.
- `cmd_rate` in RATE_W: number of `period_tick` pulses per step; 0 is treated as 1.
- `abort` in 1: stop the ramp, freezing `duty` at its current value.
- `duty` out WIDTH: registered duty value feeding the PWM core.
- `busy` out 1: ramp in progress.
- `done` out 1: one-cycle pulse when `duty` reaches the target.

## Operation
- States:
  - IDLE: `busy`=0.
  - RAMP: `busy`=1.
- Latched fields: `tgt`, `stp_eff`=max(`cmd_step`,1), `rate_eff`=max(`cmd_rate`,1).
- Internal counter: `cnt` (RATE_W bits).
- Accept: a command is accepted when `cmd_valid` && `cmd_ready` at a rising edge.
  - At that edge the fields are latched and `cnt` is cleared to 0.
  - If `cmd_target`==`duty`: the block stays in or returns to IDLE, `done`=1 next cycle, and `duty` is unchanged.
  - Otherwise the block enters RAMP.
- Counting in RAMP, on each `period_tick`:
  - If `cnt`==`rate_eff`-1: clear `cnt` and perform a step.
  - Otherwise increment `cnt`.
- Step arithmetic:
  - `diff`=|`tgt`−`duty`| is computed at WIDTH+1 bits (no wrap).
  - If `diff`<=`stp_eff`: `duty`<=`tgt`, `done`<=1, next state IDLE.
  - Otherwise `duty` moves toward `tgt` by `stp_eff`.
  - `duty` never overshoots and never wraps past 0 or 2^WIDTH−1.
- Abort in RAMP: at the next edge the block goes to IDLE, `duty` holds, `cnt` clears, and no `done` pulse is issued.
  - `abort` has priority over a simultaneous `period_tick`/step.
  - `abort` in IDLE is ignored.
- `cmd_ready`:
  - Always 1 in IDLE.
  - In RAMP, its value depends on `PWM_RAMP_RETARGET_EN` (see Configuration).
- `done` is high for exactly one cycle per completed ramp or immediate-match command.
- Reset mid-ramp (`rst_n` high at any time) asynchronously forces: IDLE, `duty`=0, `cnt`=0, `tgt`=0, `done`=0, `busy`=0.

## Timing
- Reset values of all outputs: `duty`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- `cmd_ready` is combinational from state and `abort`; `duty`, `busy` and `done` are registered.
- Command accepted at edge E: `busy`=1 in the cycle after E. `duty` is first changed no earlier than the edge that samples the `rate_eff`-th subsequent `period_tick`.
- Step latency: a `period_tick` sampled in cycle T that completes the count produces the new `duty` in cycle T+1.
- Final step at the edge ending cycle T:
  - In cycle T+1: `duty`=`tgt`, `done`=1, `busy`=0, `cmd_ready`=1.
  - A new command may be accepted at the edge ending T+1.
- Full ramp length: ceil(|`tgt`−`duty0`| / `stp_eff`) × `rate_eff` PWM periods.
- Back-to-back `period_tick` (every cycle) must be handled; each pulse counts once.

## Configuration
- `PWM_RAMP_RETARGET_EN` defined (retargeting enabled):
  - In RAMP, `cmd_ready` = !`abort`, so a new command is accepted mid-ramp.
  - On acceptance, `tgt`/`stp_eff`/`rate_eff` are replaced and `cnt` is cleared; `duty` keeps its current value; any simultaneous `period_tick` is ignored.
  - If the new target equals the current `duty`: `done` pulses and the block returns to IDLE.
- `PWM_RAMP_RETARGET_EN` not defined:
  - `cmd_ready`=0 throughout RAMP.
  - Commands presented during a ramp stall until IDLE.

## Test plan
- Reset, then command target=40, step=10, rate=2, with `period_tick` every 5 cycles → `duty` steps through 10, 20, 30, 40 on every second tick; `done` is a single pulse as `duty` becomes 40; `busy` falls in the same cycle.
- From `duty`=40, command target=5, step=10, rate=1 → `duty` goes 30, 20, 10, 5 (clamped, no underflow), then `done`.
- Command target=255, step=0, rate=0, from `duty`=253 → treated as step 1, rate 1: 254 then 255, no wrap; then command target=255 → `done` pulses next cycle, `busy` stays 0.
- Mid-ramp `abort` asserted in the same cycle as a step-completing `period_tick` → `duty` holds its pre-step value, IDLE, no `done`, `cmd_ready`=1.
- Mid-ramp `rst_n` pulse between clock edges → `duty`=0 and `busy`=0 immediately; the ramp does not resume after release.
- With the macro defined: during the 0→100 ramp (step 10), at `duty`=30 issue target=0 → accepted in the same cycle, `cnt` cleared, `duty` ramps 20, 10, 0, then `done`. Without the macro: `cmd_ready`=0 until the first ramp's `done`, then the command is accepted.
